// File: rtl/nor_prog_seq.sv
// Wishbone pipelined master feeding nor_bus: issues the NOR unlock/program write
// sequence for one word, then polls it until it reads back or the poll budget runs out.
module nor_prog_seq #(
  parameter int unsigned ADDRBITS  = 26,
  parameter int unsigned DATABITS  = 16,
  parameter int unsigned MAX_POLLS = 64,
  parameter int unsigned POLL_GAP  = 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [ADDRBITS-1:0] req_addr_i,
  input  logic [DATABITS-1:0] req_data_i,
  output logic                done_o,
  output logic [1:0]          status_o,
  output logic                busy_o,
  output logic [ADDRBITS-1:0] wbm_adr_o,
  output logic [DATABITS-1:0] wbm_dat_o,
  output logic                wbm_we_o,
  output logic                wbm_stb_o,
  output logic                wbm_cyc_o,
  input  logic                wbm_ack_i,
  input  logic                wbm_stall_i,
  input  logic                wbm_err_i,
  input  logic [DATABITS-1:0] wbm_dat_i
);

  localparam int unsigned PCW = $clog2(MAX_POLLS + 1);
  localparam int unsigned GCW = $clog2(POLL_GAP + 1);
  localparam int unsigned OCW = 3;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_BUSERR  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_CMD_WAIT, S_GAP, S_POLL, S_POLL_WAIT, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDRBITS-1:0] addr_q, addr_d;
  logic [DATABITS-1:0] data_q, data_d;
  logic [1:0]          beat_q, beat_d;
  logic [OCW-1:0]      outst_q, outst_d;
  logic [2:0]          acks_q, acks_d;
  logic [PCW-1:0]      poll_q, poll_d;
  logic [GCW-1:0]      gap_q, gap_d;

  logic                ready_d, done_d, busy_d, we_d, stb_d, cyc_d;
  logic [1:0]          status_d;
  logic [ADDRBITS-1:0] adr_d;
  logic [DATABITS-1:0] dat_d;

  logic                beat_fire_c, ack_ok_c, err_hit_c, abort_c;
  logic [1:0]          beat_n_c;
  logic [PCW-1:0]      poll_n_c;

  assign beat_fire_c = wbm_cyc_o && wbm_stb_o && !wbm_stall_i;
  assign ack_ok_c    = wbm_cyc_o && wbm_ack_i && (outst_q != '0);
  assign err_hit_c   = wbm_cyc_o && wbm_err_i;
  assign beat_n_c    = beat_q + 2'd1;
  assign poll_n_c    = poll_q + PCW'(1);

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    beat_d   = beat_q;
    acks_d   = acks_q;
    poll_d   = poll_q;
    gap_d    = gap_q;
    ready_d  = req_ready_o;
    done_d   = 1'b0;
    status_d = ST_OK;
    busy_d   = busy_o;
    adr_d    = wbm_adr_o;
    dat_d    = wbm_dat_o;
    we_d     = wbm_we_o;
    stb_d    = wbm_stb_o;
    cyc_d    = wbm_cyc_o;
    abort_c  = 1'b0;

    unique case ({beat_fire_c, ack_ok_c})
      2'b10:   outst_d = outst_q + OCW'(1);
      2'b01:   outst_d = outst_q - OCW'(1);
      default: outst_d = outst_q;
    endcase

    unique case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (req_valid_i && req_ready_o) begin
          addr_d  = req_addr_i;
          data_d  = req_data_i;
          beat_d  = 2'd0;
          acks_d  = 3'd0;
          poll_d  = '0;
          outst_d = '0;
          adr_d   = ADDRBITS'(12'h555);
          dat_d   = DATABITS'(16'h00AA);
          we_d    = 1'b1;
          stb_d   = 1'b1;
          cyc_d   = 1'b1;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (err_hit_c) begin
          abort_c = 1'b1;
        end else begin
          if (ack_ok_c) acks_d = acks_q + 3'd1;
          if (beat_fire_c) begin
            if (beat_q == 2'd3) begin
              stb_d   = 1'b0;
              state_d = S_CMD_WAIT;
            end else begin
              beat_d = beat_n_c;
              unique case (beat_n_c)
                2'd1: begin adr_d = ADDRBITS'(12'h2AA); dat_d = DATABITS'(16'h0055); end
                2'd2: begin adr_d = ADDRBITS'(12'h555); dat_d = DATABITS'(16'h00A0); end
                default: begin adr_d = addr_q; dat_d = data_q; end
              endcase
            end
          end
        end
      end
      S_CMD_WAIT: begin
        if (err_hit_c) begin
          abort_c = 1'b1;
        end else if (ack_ok_c) begin
          if (acks_q == 3'd3) begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            we_d    = 1'b0;
            gap_d   = '0;
            state_d = S_GAP;
          end else begin
            acks_d = acks_q + 3'd1;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GCW'(POLL_GAP - 1)) begin
          adr_d   = addr_q;
          we_d    = 1'b0;
          stb_d   = 1'b1;
          cyc_d   = 1'b1;
          state_d = S_POLL;
        end else begin
          gap_d = gap_q + GCW'(1);
        end
      end
      S_POLL: begin
        if (err_hit_c) begin
          abort_c = 1'b1;
        end else if (beat_fire_c) begin
          stb_d   = 1'b0;
          state_d = S_POLL_WAIT;
        end
      end
      S_POLL_WAIT: begin
        if (err_hit_c) begin
          abort_c = 1'b1;
        end else if (ack_ok_c) begin
          poll_d = poll_n_c;
          cyc_d  = 1'b0;
          // A matching readback wins even on the final allowed poll.
          if (wbm_dat_i == data_q) begin
            done_d   = 1'b1;
            status_d = ST_OK;
            state_d  = S_DONE;
          end else if (poll_n_c == PCW'(MAX_POLLS)) begin
            done_d   = 1'b1;
            status_d = ST_TIMEOUT;
            state_d  = S_DONE;
          end else begin
            gap_d   = '0;
            state_d = S_GAP;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase

    // Bus error terminates the whole request; nothing more goes on the bus.
    if (abort_c) begin
      cyc_d    = 1'b0;
      stb_d    = 1'b0;
      we_d     = 1'b0;
      outst_d  = '0;
      done_d   = 1'b1;
      status_d = ST_BUSERR;
      state_d  = S_DONE;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      beat_q      <= '0;
      outst_q     <= '0;
      acks_q      <= '0;
      poll_q      <= '0;
      gap_q       <= '0;
      req_ready_o <= 1'b1;
      done_o      <= 1'b0;
      status_o    <= 2'b00;
      busy_o      <= 1'b0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      wbm_we_o    <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_cyc_o   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      beat_q      <= beat_d;
      outst_q     <= outst_d;
      acks_q      <= acks_d;
      poll_q      <= poll_d;
      gap_q       <= gap_d;
      req_ready_o <= ready_d;
      done_o      <= done_d;
      status_o    <= status_d;
      busy_o      <= busy_d;
      wbm_adr_o   <= adr_d;
      wbm_dat_o   <= dat_d;
      wbm_we_o    <= we_d;
      wbm_stb_o   <= stb_d;
      wbm_cyc_o   <= cyc_d;
    end
  end

endmodule

// File: tb/tb_nor_prog_seq.sv
// Directed bench for nor_prog_seq: table of program requests against a small
// pipelined wishbone slave, plus reset-in-GAP and back-to-back request sequences.
module tb_nor_prog_seq;

  localparam int unsigned AW = 26;
  localparam int unsigned DW = 16;
  localparam int unsigned MP = 4;
  localparam int unsigned PG = 3;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i;
  logic [DW-1:0] req_data_i;
  logic          done_o;
  logic [1:0]    status_o;
  logic          busy_o;
  logic [AW-1:0] wbm_adr_o;
  logic [DW-1:0] wbm_dat_o;
  logic          wbm_we_o, wbm_stb_o, wbm_cyc_o;
  logic          wbm_ack_i, wbm_stall_i, wbm_err_i;
  logic [DW-1:0] wbm_dat_i;

  always #5 clk = ~clk;

  nor_prog_seq #(.ADDRBITS(AW), .DATABITS(DW), .MAX_POLLS(MP), .POLL_GAP(PG)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .done_o(done_o), .status_o(status_o), .busy_o(busy_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_we_o(wbm_we_o),
    .wbm_stb_o(wbm_stb_o), .wbm_cyc_o(wbm_cyc_o),
    .wbm_ack_i(wbm_ack_i), .wbm_stall_i(wbm_stall_i), .wbm_err_i(wbm_err_i),
    .wbm_dat_i(wbm_dat_i)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            match_at;   // index of first poll that returns the programmed word
    int            stall_n;    // stall cycles applied to the (2AA,0055) beat
    int            err_at;     // response index replaced by err (-1: none)
    logic [1:0]    exp_status;
    int            exp_reads;
    int            exp_writes;
    int            exp_hold;   // cycles (2AA,0055) write is presented
  } vec_t;

  vec_t vecs[7];

  int checks = 0;
  int errors = 0;

  // slave configuration and observations
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_data;
  int cfg_match_at, cfg_err_at, stall_left;
  logic [AW-1:0] wr_adr[$];
  logic [DW-1:0] wr_dat[$];
  int rd_cnt, rd_resp, resp_cnt, bad_rd_adr, hold_cnt, min_idle, idle_run;
  int done_cnt, cyc_after_err_bad;
  logic [1:0] last_status;
  bit pend, pend_rd, err_prev;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon(input vec_t v);
    wr_adr.delete();
    wr_dat.delete();
    rd_cnt = 0; rd_resp = 0; resp_cnt = 0; bad_rd_adr = 0; hold_cnt = 0;
    min_idle = 1000; idle_run = 0; done_cnt = 0; cyc_after_err_bad = 0;
    last_status = 2'b11;
    cfg_addr = v.addr; cfg_data = v.data;
    cfg_match_at = v.match_at; cfg_err_at = v.err_at; stall_left = v.stall_n;
  endtask

  // Pipelined slave: acks each accepted beat one cycle later; err replaces a chosen response.
  initial begin
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_stall_i = 1'b0; wbm_dat_i = '0;
    pend = 0; pend_rd = 0; err_prev = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_stall_i = 1'b0;
        pend = 0; err_prev = 0;
      end else begin
        if (err_prev && wbm_cyc_o) cyc_after_err_bad++;
        err_prev = 0;
        if (done_o) begin done_cnt++; last_status = status_o; end
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_stall_i = 1'b0;
        if (pend) begin
          if (resp_cnt == cfg_err_at) begin
            wbm_err_i = 1'b1; wbm_stall_i = 1'b1; err_prev = 1;
          end else begin
            wbm_ack_i = 1'b1;
            if (pend_rd) begin
              wbm_dat_i = (rd_resp >= cfg_match_at) ? cfg_data : '0;
              rd_resp++;
            end
          end
          resp_cnt++;
        end
        pend = 0;
        if (wbm_cyc_o && wbm_stb_o) begin
          if (wbm_we_o && wbm_adr_o == AW'(12'h2AA) && wbm_dat_o == DW'(16'h0055)) begin
            hold_cnt++;
            if (stall_left > 0) begin wbm_stall_i = 1'b1; stall_left--; end
          end
          if (!wbm_stall_i) begin
            pend = 1; pend_rd = !wbm_we_o;
            if (wbm_we_o) begin
              wr_adr.push_back(wbm_adr_o);
              wr_dat.push_back(wbm_dat_o);
            end else begin
              rd_cnt++;
              if (wbm_adr_o != cfg_addr) bad_rd_adr++;
              if (idle_run < min_idle) min_idle = idle_run;
            end
          end
        end
        if (wbm_cyc_o) idle_run = 0; else idle_run++;
      end
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    logic [AW-1:0] ea[4];
    logic [DW-1:0] ed[4];
    int n;
    string s;
    s = $sformatf("v%0d", idx);
    ea[0] = AW'(12'h555); ea[1] = AW'(12'h2AA); ea[2] = AW'(12'h555); ea[3] = v.addr;
    ed[0] = DW'(16'h00AA); ed[1] = DW'(16'h0055); ed[2] = DW'(16'h00A0); ed[3] = v.data;
    clear_mon(v);
    req_addr_i = v.addr; req_data_i = v.data; req_valid_i = 1'b1;
    chk({s, "_ready_idle"}, 64'(req_ready_o), 64'd1);
    tick();
    req_valid_i = 1'b0;
    chk({s, "_busy_accept"}, 64'(busy_o), 64'd1);
    n = 0;
    while (done_cnt == 0 && n < 400) begin tick(); n++; end
    chk({s, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
    repeat (3) tick();
    chk({s, "_status"}, 64'(last_status), 64'(v.exp_status));
    chk({s, "_done_pulses"}, 64'(done_cnt), 64'd1);
    chk({s, "_writes"}, 64'(wr_adr.size()), 64'(v.exp_writes));
    for (int i = 0; i < v.exp_writes; i++) begin
      if (i < wr_adr.size()) begin
        chk($sformatf("%s_wr%0d_adr", s, i), 64'(wr_adr[i]), 64'(ea[i]));
        chk($sformatf("%s_wr%0d_dat", s, i), 64'(wr_dat[i]), 64'(ed[i]));
      end
    end
    chk({s, "_reads"}, 64'(rd_cnt), 64'(v.exp_reads));
    chk({s, "_read_adr"}, 64'(bad_rd_adr), 64'd0);
    chk({s, "_hold"}, 64'(hold_cnt), 64'(v.exp_hold));
    if (v.exp_reads > 0) chk({s, "_poll_gap"}, 64'(min_idle >= int'(PG)), 64'd1);
    chk({s, "_cyc_after_err"}, 64'(cyc_after_err_bad), 64'd0);
    chk({s, "_idle_ready"}, 64'({req_ready_o, busy_o, wbm_cyc_o, status_o}), 64'b10000);
  endtask

  initial begin
    int n;
    vec_t b;
    vecs[0] = '{26'h0001234, 16'hBEEF, 0,  0, -1, 2'b00, 1, 4, 1};
    vecs[1] = '{26'h3FFFFFF, 16'h1357, 0,  3, -1, 2'b00, 1, 4, 4};
    vecs[2] = '{26'h0000042, 16'hA5A5, 99, 0, -1, 2'b01, 4, 4, 1};
    vecs[3] = '{26'h0000100, 16'h0F0F, 3,  0, -1, 2'b00, 4, 4, 1};
    vecs[4] = '{26'h0000200, 16'h1111, 0,  0,  2, 2'b10, 0, 3, 1};
    vecs[5] = '{26'h0000300, 16'h2222, 0,  0,  4, 2'b10, 1, 4, 1};
    vecs[6] = '{26'h00002AA, 16'h0055, 1,  2, -1, 2'b00, 2, 4, 4};

    req_valid_i = 1'b0; req_addr_i = '0; req_data_i = '0;
    clear_mon(vecs[0]);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready", 64'(req_ready_o), 64'd1);
    chk("rst_outs", 64'({done_o, status_o, busy_o, wbm_we_o, wbm_stb_o, wbm_cyc_o}), 64'd0);
    chk("rst_bus", 64'({wbm_adr_o, wbm_dat_o}), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // reset pulled during GAP: immediate reset values, no completion
    clear_mon(vecs[2]);
    req_addr_i = vecs[2].addr; req_data_i = vecs[2].data; req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    n = 0;
    while (!(wr_adr.size() == 4 && !wbm_cyc_o) && n < 100) begin tick(); n++; end
    chk("gap_reached", 64'(wr_adr.size() == 4 && !wbm_cyc_o && busy_o), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 64'(req_ready_o), 64'd1);
    chk("midrst_outs", 64'({done_o, status_o, busy_o, wbm_we_o, wbm_stb_o, wbm_cyc_o}), 64'd0);
    chk("midrst_bus", 64'({wbm_adr_o, wbm_dat_o}), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (12) tick();
    chk("midrst_no_done", 64'(done_cnt), 64'd0);
    chk("midrst_no_poll", 64'(rd_cnt), 64'd0);
    run_vec(vecs[0], 7);

    // two requests with valid held high across DONE
    b = '{26'h0000ABC, 16'h4321, 0, 0, -1, 2'b00, 1, 4, 1};
    clear_mon(vecs[0]);
    req_addr_i = vecs[0].addr; req_data_i = vecs[0].data; req_valid_i = 1'b1;
    n = 0;
    while (done_cnt == 0 && n < 400) begin tick(); n++; end
    chk("b2b_done1", 64'(done_cnt), 64'd1);
    chk("b2b_in_done", 64'({req_ready_o, busy_o, done_o}), 64'b011);
    req_addr_i = b.addr; req_data_i = b.data;
    cfg_addr = b.addr; cfg_data = b.data;
    wr_adr.delete(); wr_dat.delete();
    tick();
    chk("b2b_idle", 64'({req_ready_o, busy_o}), 64'b10);
    tick();
    chk("b2b_accept2", 64'({req_ready_o, busy_o, wbm_cyc_o}), 64'b011);
    req_valid_i = 1'b0;
    n = 0;
    while (done_cnt < 2 && n < 400) begin tick(); n++; end
    repeat (3) tick();
    chk("b2b_done2", 64'(done_cnt), 64'd2);
    chk("b2b_status2", 64'(last_status), 64'd0);
    chk("b2b_writes2", 64'(wr_adr.size()), 64'd4);
    if (wr_adr.size() >= 4) begin
      chk("b2b_wr3_adr", 64'(wr_adr[3]), 64'(b.addr));
      chk("b2b_wr3_dat", 64'(wr_dat[3]), 64'(b.data));
    end
    chk("b2b_end_idle", 64'({req_ready_o, busy_o}), 64'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
